// File: rtl/stage_decode_hs_pkg.sv
// Shared types for the handshaked ID stage: opcodes, branch codes, control and ID-EX packets.
package stage_decode_hs_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    typedef enum logic [0:0] {StIdle, StStall} decode_hazard_e;
    typedef enum logic [1:0] {Op1Rs1, Op1Pc, Op1Zero} op1_sel_e;
    typedef enum logic [2:0] {Op2Rs2, Op2ImmI, Op2ImmS, Op2ImmU, Op2ImmJ, Op2Zero} op2_sel_e;
    typedef enum logic [1:0] {WbAlu, WbMem, WbPc4} wb_sel_e;

    typedef struct packed {
        op1_sel_e   op1_sel;
        op2_sel_e   op2_sel;
        logic [3:0] alu_fun;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        wb_sel_e    wb_sel;
        logic       uses_rs1;
        logic       uses_rs2;
    } ctrl_t;

    typedef struct packed {
        logic        instr_valid;
        logic [2:0]  func3;
        logic [3:0]  alu_fun;
        logic [31:0] alu_op1;
        logic [31:0] alu_op2;
        logic [31:0] store_data;
        logic        mem_rd;
        logic        mem_wr;
        logic        reg_wr;
        logic [4:0]  reg_wr_addr;
        logic [1:0]  wb_sel;
        logic [31:0] pc_plus_four;
    } id_ex_reg_t;

    // Control decode; alu_fun is {funct7[5], func3} for ALU ops and ADD otherwise.
    function automatic ctrl_t decode_ctrl(input logic [6:0] opcode, input logic [2:0] func3,
                                          input logic funct7_5);
        ctrl_t c;
        c          = '0;
        c.op1_sel  = Op1Zero;
        c.op2_sel  = Op2Zero;
        c.wb_sel   = WbAlu;
        c.uses_rs1 = 1'b1;
        case (opcode)
            OP_LUI:    begin c.op2_sel = Op2ImmU; c.reg_wr = 1'b1; c.uses_rs1 = 1'b0; end
            OP_AUIPC:  begin
                c.op1_sel = Op1Pc; c.op2_sel = Op2ImmU; c.reg_wr = 1'b1; c.uses_rs1 = 1'b0;
            end
            OP_JAL:    begin
                c.op1_sel = Op1Pc; c.op2_sel = Op2ImmJ; c.reg_wr = 1'b1; c.wb_sel = WbPc4;
                c.uses_rs1 = 1'b0;
            end
            OP_JALR:   begin
                c.op1_sel = Op1Rs1; c.op2_sel = Op2ImmI; c.reg_wr = 1'b1; c.wb_sel = WbPc4;
            end
            OP_BRANCH: begin c.op1_sel = Op1Rs1; c.op2_sel = Op2Rs2; c.uses_rs2 = 1'b1; end
            OP_LOAD:   begin
                c.op1_sel = Op1Rs1; c.op2_sel = Op2ImmI; c.mem_rd = 1'b1; c.reg_wr = 1'b1;
                c.wb_sel = WbMem;
            end
            OP_STORE:  begin
                c.op1_sel = Op1Rs1; c.op2_sel = Op2ImmS; c.mem_wr = 1'b1; c.uses_rs2 = 1'b1;
            end
            OP_IMM:    begin
                c.op1_sel = Op1Rs1; c.op2_sel = Op2ImmI; c.reg_wr = 1'b1;
                c.alu_fun = {(func3 == 3'b101) & funct7_5, func3};
            end
            OP_REG:    begin
                c.op1_sel = Op1Rs1; c.op2_sel = Op2Rs2; c.reg_wr = 1'b1; c.uses_rs2 = 1'b1;
                c.alu_fun = {funct7_5, func3};
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/id_ex_queue.sv
// Synchronous FIFO for ID-EX packets; flush empties it, simultaneous push/pop on full is legal.
module id_ex_queue
    import stage_decode_hs_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter type         T     = id_ex_reg_t
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic flush,
    input  logic enq_valid,
    input  T     enq_data,
    input  logic deq_ready,
    output T     deq_data,
    output logic full,
    output logic empty
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth) + 1;

    T                mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_enq, do_deq;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == CntW'(Depth));
    assign empty    = (count_q == '0);
    assign do_deq   = deq_ready && !empty;
    assign do_enq   = enq_valid && (!full || do_deq);
    assign deq_data = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (!rst_ni || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_enq) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_deq) rd_ptr_q <= next_ptr(rd_ptr_q);
            case ({do_enq, do_deq})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_ni && !flush && do_enq) mem_q[wr_ptr_q] <= enq_data;
    end

endmodule

// File: rtl/stage_decode_hs.sv
// RV32I decode stage with valid/ready handshakes, in-ID branch resolution and load-use stalls.
module stage_decode_hs
    import stage_decode_hs_pkg::*;
#(
    parameter int unsigned OUT_DEPTH         = 2,
    parameter int unsigned LOADUSE_STALL     = 1,
    parameter bit          EN_BRANCH_RESOLVE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        if_valid_i,
    output logic        if_ready_o,
    input  logic [31:0] instr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus_four_i,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic        ex_load_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        squash_i,
    output logic        redirect_o,
    output logic [31:0] redirect_addr_o,
    output logic        id_ex_valid_o,
    input  logic        id_ex_ready_i,
    output id_ex_reg_t  id_ex_o,
    output logic [31:0] bubble_cnt_o
);
    logic [6:0]     opcode;
    logic [2:0]     func3;
    ctrl_t          ctrl;
    logic [31:0]    imm_i, imm_s, imm_b, imm_u, imm_j, op1, op2, redirect_target;
    logic           br_cond, take_redirect, hazard, fire_in, q_full, q_empty;
    id_ex_reg_t     pkt;
    decode_hazard_e state_q;
    logic [2:0]     stall_cnt_q;
    logic           hz_done_q, redirect_q;
    logic [31:0]    redirect_addr_q, bubble_cnt_q;

    assign opcode     = instr_i[6:0];
    assign func3      = instr_i[14:12];
    assign ctrl       = decode_ctrl(opcode, func3, instr_i[30]);
    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];

    assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u = {instr_i[31:12], 12'b0};
    assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21],
                    1'b0};

    always_comb begin
        unique case (ctrl.op1_sel)
            Op1Rs1:  op1 = rs1_data_i;
            Op1Pc:   op1 = pc_i;
            default: op1 = '0;
        endcase
        unique case (ctrl.op2_sel)
            Op2Rs2:  op2 = rs2_data_i;
            Op2ImmI: op2 = imm_i;
            Op2ImmS: op2 = imm_s;
            Op2ImmU: op2 = imm_u;
            Op2ImmJ: op2 = imm_j;
            default: op2 = '0;
        endcase
    end

    always_comb begin
        case (func3)
            BR_EQ:   br_cond = (rs1_data_i == rs2_data_i);
            BR_NE:   br_cond = (rs1_data_i != rs2_data_i);
            BR_LT:   br_cond = ($signed(rs1_data_i) < $signed(rs2_data_i));
            BR_GE:   br_cond = ($signed(rs1_data_i) >= $signed(rs2_data_i));
            BR_LTU:  br_cond = (rs1_data_i < rs2_data_i);
            BR_GEU:  br_cond = (rs1_data_i >= rs2_data_i);
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        redirect_target = pc_i + imm_b;
        if (opcode == OP_JAL)       redirect_target = pc_i + imm_j;
        else if (opcode == OP_JALR) redirect_target = (rs1_data_i + imm_i) & ~32'd1;
    end

    assign take_redirect = (opcode == OP_JAL) || (opcode == OP_JALR) ||
                           (EN_BRANCH_RESOLVE && (opcode == OP_BRANCH) && br_cond);

    assign hazard = ex_load_i && (ex_rd_addr_i != 5'd0) &&
                    ((ctrl.uses_rs1 && (rs1_addr_o == ex_rd_addr_i)) ||
                     (ctrl.uses_rs2 && (rs2_addr_o == ex_rd_addr_i)));

    assign if_ready_o = rst_ni && !squash_i && (stall_cnt_q == 3'd0) && !(hazard && !hz_done_q) &&
                        (!q_full || id_ex_ready_i);
    assign fire_in    = if_valid_i && if_ready_o;

    always_comb begin
        pkt              = '0;
        pkt.instr_valid  = 1'b1;
        pkt.func3        = func3;
        pkt.alu_fun      = ctrl.alu_fun;
        pkt.alu_op1      = op1;
        pkt.alu_op2      = op2;
        pkt.store_data   = rs2_data_i;
        pkt.mem_rd       = ctrl.mem_rd;
        pkt.mem_wr       = ctrl.mem_wr;
        pkt.reg_wr       = ctrl.reg_wr;
        pkt.reg_wr_addr  = instr_i[11:7];
        pkt.wb_sel       = ctrl.wb_sel;
        pkt.pc_plus_four = pc_plus_four_i;
    end

    id_ex_queue #(
        .Depth (OUT_DEPTH),
        .T     (id_ex_reg_t)
    ) u_queue (
        .clk       (clk),
        .rst_ni    (rst_ni),
        .flush     (squash_i),
        .enq_valid (fire_in),
        .enq_data  (pkt),
        .deq_ready (id_ex_ready_i),
        .deq_data  (id_ex_o),
        .full      (q_full),
        .empty     (q_empty)
    );

    // hz_done lets the held instruction through once its bubbles have been served.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            stall_cnt_q  <= '0;
            hz_done_q    <= 1'b0;
            bubble_cnt_q <= '0;
        end else if (squash_i) begin
            state_q     <= StIdle;
            stall_cnt_q <= '0;
            hz_done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (if_valid_i && hazard && !hz_done_q) begin
                        state_q     <= StStall;
                        stall_cnt_q <= 3'(LOADUSE_STALL);
                    end else if (fire_in) begin
                        hz_done_q <= 1'b0;
                    end
                end
                StStall: begin
                    stall_cnt_q <= stall_cnt_q - 3'd1;
                    if (bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_q <= bubble_cnt_q + 32'd1;
                    if (stall_cnt_q == 3'd1) begin
                        state_q   <= StIdle;
                        hz_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            redirect_q      <= 1'b0;
            redirect_addr_q <= '0;
        end else begin
            redirect_q <= fire_in && take_redirect;
            if (fire_in && take_redirect) redirect_addr_q <= redirect_target;
        end
    end

    assign redirect_o      = redirect_q;
    assign redirect_addr_o = redirect_addr_q;
    assign id_ex_valid_o   = !q_empty;
    assign bubble_cnt_o    = bubble_cnt_q;

endmodule
